fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that feeds the decode stage (register file read, immediate generation, control) with a valid 32-bit instruction and its PC.
- Owns the PC register and runs a req/ready handshake with instruction memory, which may insert wait states.
- Holds a one-entry skid buffer so a decode stall never loses a returned word.
- Accepts a redirect (branch/JAL/JALR target computed downstream from PC + immediate) that flushes in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0013, instruction word driven on inst while invalid (addi x0,x0,0).

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word address of request (always pc, bits [1:0]=0).
imem_ready  input  1  memory returns imem_rdata this cycle; sampled only when imem_req=1.
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
stall  input  1  decode cannot accept inst this cycle.
redirect  input  1  taken branch/jump; overrides everything.
redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0 internally.
inst_valid  output  1  inst/inst_pc hold a live instruction.
inst  output  32  instruction to decode.
inst_pc  output  32  PC of inst.
fetch_count  output  32  number of instructions accepted by decode, wraps at 2^32.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, state=BOOT, inst_valid=0, inst=NOP_INST, inst_pc=RESET_PC.
  - Skid buffer empty, fetch_count=0, imem_req=0.
- Handshake:
  - Decode accepts on any edge with inst_valid && !stall.
  - Memory transfer completes on any edge with imem_req && imem_ready.
  - imem_addr stays stable while imem_req=1 and no redirect.
- States:
  - BOOT: imem_req=0 for exactly one cycle after reset release; then FETCH.
  - FETCH: imem_req=1, imem_addr=pc.
    - On transfer, if output slot is free (!inst_valid or accepted this edge): inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4; stay FETCH.
    - On transfer, if slot is occupied and stalled: word and pc go to skid buffer, pc<=pc+4, go to FULL.
    - No transfer: if output is accepted, inst_valid<=0, inst<=NOP_INST.
  - FULL: imem_req=0. On the edge where stall=0, skid buffer moves to inst/inst_pc (inst_valid stays 1), buffer empties, go to FETCH.
- Throughput: with imem_ready tied 1 and stall=0, one instruction per cycle. Latency from transfer edge to inst_valid=1 is 0 cycles (registered at that edge).
- Redirect (highest priority, any state except BOOT):
  - pc<={redirect_pc[31:2],2'b00}, inst_valid<=0, inst<=NOP_INST, skid buffer cleared, state<=FETCH.
  - A memory transfer completing on the same edge is discarded; pc is not incremented.
  - The instruction at inst is not counted even if stall=0.
  - imem_req may drop or change address mid-wait on redirect; instruction memory is stateless.
- Redirect during BOOT: latched into pc; BOOT still lasts its one cycle.
- fetch_count increments by 1 on each decode acceptance not coinciding with redirect; 32'hFFFF_FFFF wraps to 0.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC increments to 0.
- Reset asserted mid-wait or mid-FULL: immediate return to reset values; the pending word is lost.

Test Plan:
- Reset release, imem_ready=1, stall=0, memory returns addr+1 → imem_req low for 1 cycle. Then inst_pc=0,4,8 on consecutive cycles with inst=1,5,9; fetch_count=3 after 3 accepts.
- imem_ready pulsed every 3rd cycle → imem_addr holds 0x0 for 3 cycles and inst_valid gaps appear. No PC is skipped or duplicated.
- stall=1 for 4 cycles while a second word returns → inst stays at PC 0x0, state FULL, imem_req=0. Stall release gives PC 0x4 then fetching resumes at 0x8.
- redirect=1, redirect_pc=0x0000_0103 with imem_ready=1 on the same edge → returned word dropped, inst_valid=0 next cycle. Next imem_addr=0x100; fetch_count unchanged.
- Redirect while in FULL → skid buffer discarded, next delivered inst_pc equals the redirect target.
- pc=0xFFFF_FFFC fetch → next imem_addr=0x0. fetch_count preloaded near 0xFFFF_FFFF wraps to 0. rst_n asserted mid-wait returns all outputs to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// and presents one instruction at a time to decode with a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] count_q, count_d;

  logic accept;
  logic xfer;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    count_d      = count_q;

    imem_req = (state_q == FETCH);
    accept   = inst_valid_q && !stall;
    xfer     = imem_req && imem_ready;

    if (accept && !redirect) begin
      count_d = count_q + 32'd1;
    end

    // Redirect wins over everything, including a transfer on the same edge.
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      skid_inst_d  = '0;
      skid_pc_d    = '0;
      state_d      = FETCH;
    end else begin
      unique case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (xfer) begin
            pc_d = pc_q + 32'd4;
            if (!inst_valid_q || !stall) begin
              inst_valid_d = 1'b1;
              inst_d       = imem_rdata;
              inst_pc_d    = pc_q;
            end else begin
              skid_inst_d = imem_rdata;
              skid_pc_d   = pc_q;
              state_d     = FULL;
            end
          end else if (accept) begin
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
          end
        end
        FULL: begin
          if (!stall) begin
            inst_d      = skid_inst_q;
            inst_pc_d   = skid_pc_q;
            skid_inst_d = '0;
            skid_pc_d   = '0;
            state_d     = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory returns addr+1, expected accepted
// instructions are queued by the stimulus and popped by an independent monitor.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_q.push_back({pc, pc + 32'd1});
  endtask

  // Monitor: an acceptance happens on the next edge whenever valid && !stall && !redirect.
  always @(negedge clk) begin
    if (rst_n && inst_valid && !stall && !redirect) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_accept: got pc %h expected none", inst_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("acc_pc", inst_pc, e[63:32]);
        chk("acc_inst", inst, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_cnt", fetch_count, 32'd0);

    // Streaming: one per cycle after a single BOOT cycle.
    push(32'h0); push(32'h4); push(32'h8);
    cyc(); rst_n = 1'b1; imem_ready = 1'b1;
    @(negedge clk); chk("boot_req", {31'd0, imem_req}, 32'd0);
    cyc();
    @(negedge clk); chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, 32'h0);
    cyc(); cyc(); cyc();
    imem_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk("stream_cnt", fetch_count, 32'd3);
    chk("stream_valid", {31'd0, inst_valid}, 32'd0);
    chk("stream_addr", imem_addr, 32'hC);

    // Wait states: ready every third cycle, address must hold.
    push(32'hC); push(32'h10); push(32'h14);
    for (int c = 0; c < 9; c++) begin
      imem_ready = (c % 3 == 2);
      @(negedge clk);
      chk("ws_addr", imem_addr, 32'hC + 32'd4 * (c / 3));
      cyc();
    end
    imem_ready = 1'b0;
    cyc();

    // Stall with a second word returning fills the skid buffer.
    push(32'h18); push(32'h1C); push(32'h20);
    imem_ready = 1'b1; cyc();
    stall = 1'b1; cyc();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("full_req", {31'd0, imem_req}, 32'd0);
      chk("full_pc", inst_pc, 32'h18);
      chk("full_valid", {31'd0, inst_valid}, 32'd1);
      cyc();
    end
    stall = 1'b0; cyc();
    @(negedge clk);
    chk("drain_pc", inst_pc, 32'h1C);
    chk("resume_addr", imem_addr, 32'h20);
    cyc();
    imem_ready = 1'b0; cyc();
    chk("full_cnt", fetch_count, 32'd9);

    // Redirect coinciding with a transfer and a live, unstalled instruction.
    imem_ready = 1'b1; cyc();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; cyc();
    redirect = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_inst", inst, NOP);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_cnt", fetch_count, 32'd9);
    push(32'h100);
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();

    // Redirect while FULL discards the skid buffer.
    imem_ready = 1'b1; cyc();
    stall = 1'b1; cyc();
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; cyc();
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("rfull_valid", {31'd0, inst_valid}, 32'd0);
    chk("rfull_addr", imem_addr, 32'h200);
    push(32'h200);
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    chk("rfull_cnt", fetch_count, 32'd11);

    // PC wraps modulo 2^32.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; cyc();
    redirect = 1'b0;
    push(32'hFFFF_FFFC); push(32'h0);
    imem_ready = 1'b1; cyc();
    @(negedge clk); chk("wrap_addr", imem_addr, 32'h0);
    cyc();
    imem_ready = 1'b0; cyc();
    chk("wrap_cnt", fetch_count, 32'd13);

    // Asynchronous reset mid-wait while an instruction is held.
    stall = 1'b1; imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_inst", inst, NOP);
    chk("arst_pc", inst_pc, 32'd0);
    chk("arst_cnt", fetch_count, 32'd0);
    chk("arst_addr", imem_addr, 32'd0);

    // Redirect during BOOT is latched; BOOT still lasts one cycle.
    stall = 1'b0;
    cyc(); rst_n = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0041;
    @(negedge clk); chk("bootr_req", {31'd0, imem_req}, 32'd0);
    cyc(); redirect = 1'b0;
    @(negedge clk);
    chk("bootr_req1", {31'd0, imem_req}, 32'd1);
    chk("bootr_addr", imem_addr, 32'h40);
    push(32'h40);
    imem_ready = 1'b1; cyc();
    imem_ready = 1'b0; cyc();
    chk("bootr_cnt", fetch_count, 32'd1);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
